// File: rtl/sc_ucontrol.sv
// Microprogrammed control unit for the uDataPath SPARC subset: sequences fetch,
// decode and execute, driving register-write, bus-mux, ALU and bus-C selects.
module sc_ucontrol #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
) (
    input  logic                                   SC_UCONTROL_CLOCK_50,
    input  logic                                   SC_UCONTROL_Reset_InHigh,
    input  logic [1:0]                             SC_UCONTROL_RegIR_OP,
    input  logic [4:0]                             SC_UCONTROL_RegIR_RD,
    input  logic [2:0]                             SC_UCONTROL_RegIR_OP2,
    input  logic [5:0]                             SC_UCONTROL_RegIR_OP3,
    input  logic [4:0]                             SC_UCONTROL_RegIR_RS1,
    input  logic                                   SC_UCONTROL_RegIR_BIT13,
    input  logic [4:0]                             SC_UCONTROL_RegIR_RS2,
    input  logic                                   SC_UCONTROL_Negative_InHigh,
    input  logic                                   SC_UCONTROL_Zero_InHigh,
    input  logic                                   SC_UCONTROL_Overflow_InHigh,
    input  logic                                   SC_UCONTROL_Carry_InHigh,
    input  logic                                   SC_UCONTROL_MemAck_InHigh,
    output logic                                   SC_UCONTROL_MemReq_OutHigh,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_UCONTROL_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UCONTROL_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UCONTROL_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_UCONTROL_ALUSelection_Out,
    output logic                                   SC_UCONTROL_BusCSel_Out,
    output logic                                   SC_UCONTROL_Illegal_OutHigh
);
    localparam int DW = DATAWIDTH_DECODER_SELECTION;
    localparam int MW = DATAWIDTH_MUX_SELECTION;
    localparam int AW = DATAWIDTH_ALU_SELECTION;

    localparam logic [3:0] STATE_IDLE      = 4'd0;
    localparam logic [3:0] STATE_FETCH     = 4'd1;
    localparam logic [3:0] STATE_DECODE    = 4'd2;
    localparam logic [3:0] STATE_ALU       = 4'd3;
    localparam logic [3:0] STATE_IMM       = 4'd4;
    localparam logic [3:0] STATE_SETHI     = 4'd5;
    localparam logic [3:0] STATE_BR_DISP   = 4'd6;
    localparam logic [3:0] STATE_CALL_LINK = 4'd7;
    localparam logic [3:0] STATE_CALL_DISP = 4'd8;
    localparam logic [3:0] STATE_PC_ADD    = 4'd9;
    localparam logic [3:0] STATE_PC_INC    = 4'd10;
    localparam logic [3:0] STATE_HALT      = 4'd11;

    localparam logic [DW-1:0] DEC_NONE  = DW'(63);
    localparam logic [DW-1:0] DEC_LINK  = DW'(15);
    localparam logic [DW-1:0] DEC_PC    = DW'(32);
    localparam logic [DW-1:0] DEC_IR    = DW'(33);
    localparam logic [DW-1:0] DEC_TEMP0 = DW'(34);
    localparam logic [MW-1:0] MUX_R0    = MW'(0);
    localparam logic [MW-1:0] MUX_PC    = MW'(32);
    localparam logic [MW-1:0] MUX_IR    = MW'(33);
    localparam logic [MW-1:0] MUX_TEMP0 = MW'(34);

    localparam logic [AW-1:0] ALU_ANDCC  = AW'(0);
    localparam logic [AW-1:0] ALU_ORCC   = AW'(1);
    localparam logic [AW-1:0] ALU_ADDCC  = AW'(3);
    localparam logic [AW-1:0] ALU_SRL    = AW'(4);
    localparam logic [AW-1:0] ALU_ADD    = AW'(8);
    localparam logic [AW-1:0] ALU_SETHI  = AW'(9);
    localparam logic [AW-1:0] ALU_SIMM13 = AW'(11);
    localparam logic [AW-1:0] ALU_DISP22 = AW'(12);
    localparam logic [AW-1:0] ALU_DISP30 = AW'(13);
    localparam logic [AW-1:0] ALU_INCPC  = AW'(14);

    typedef struct packed {
        logic          memReq;
        logic [DW-1:0] dec;
        logic [MW-1:0] muxA;
        logic [MW-1:0] muxB;
        logic [AW-1:0] alu;
        logic          busCSel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{memReq: 1'b0, dec: DEC_NONE, muxA: MUX_R0,
                                    muxB: MUX_R0, alu: ALU_ANDCC, busCSel: 1'b0};

    logic [3:0] state;
    logic [3:0] nextState;
    logic       illegal;
    logic       setIllegal;
    logic       isAluOp;
    logic       isSethi;
    logic       isBranch;
    logic       branchTaken;
    logic [3:0] cond;
    logic [AW-1:0] aluOp;
    logic [DW-1:0] rdDec;
    ctrl_t      ctrl;

    assign cond    = SC_UCONTROL_RegIR_RD[3:0];
    assign isAluOp = (SC_UCONTROL_RegIR_OP == 2'b10) &&
                     (SC_UCONTROL_RegIR_OP3 inside {6'b010000, 6'b010001, 6'b010010, 6'b100110});
    assign isSethi  = (SC_UCONTROL_RegIR_OP == 2'b00) && (SC_UCONTROL_RegIR_OP2 == 3'b100);
    assign isBranch = (SC_UCONTROL_RegIR_OP == 2'b00) && (SC_UCONTROL_RegIR_OP2 == 3'b010);
    // Writes aimed at r0 are suppressed so the hardwired zero is never disturbed.
    assign rdDec    = (SC_UCONTROL_RegIR_RD == 5'd0) ? DEC_NONE : DW'(SC_UCONTROL_RegIR_RD);

    always_comb begin
        branchTaken = 1'b0;
        case (cond)
            4'b1000: branchTaken = 1'b1;
            4'b0001: branchTaken = SC_UCONTROL_Zero_InHigh;
            4'b0101: branchTaken = SC_UCONTROL_Carry_InHigh;
            4'b0110: branchTaken = SC_UCONTROL_Negative_InHigh;
            4'b0111: branchTaken = SC_UCONTROL_Overflow_InHigh;
            default: branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        aluOp = ALU_ADDCC;
        case (SC_UCONTROL_RegIR_OP3)
            6'b010001: aluOp = ALU_ANDCC;
            6'b010010: aluOp = ALU_ORCC;
            6'b100110: aluOp = ALU_SRL;
            default:   aluOp = ALU_ADDCC;
        endcase
    end

    always_comb begin
        nextState  = state;
        setIllegal = 1'b0;
        case (state)
            STATE_IDLE:      nextState = STATE_FETCH;
            STATE_FETCH:     if (SC_UCONTROL_MemAck_InHigh) nextState = STATE_DECODE;
            STATE_DECODE: begin
                if (isAluOp)
                    nextState = SC_UCONTROL_RegIR_BIT13 ? STATE_IMM : STATE_ALU;
                else if (isSethi)
                    nextState = STATE_SETHI;
                else if (isBranch)
                    nextState = branchTaken ? STATE_BR_DISP : STATE_PC_INC;
                else if (SC_UCONTROL_RegIR_OP == 2'b01)
                    nextState = STATE_CALL_LINK;
                else begin
                    nextState  = STATE_HALT;
                    setIllegal = 1'b1;
                end
            end
            STATE_ALU:       nextState = STATE_PC_INC;
            STATE_IMM:       nextState = STATE_ALU;
            STATE_SETHI:     nextState = STATE_PC_INC;
            STATE_BR_DISP:   nextState = STATE_PC_ADD;
            STATE_CALL_LINK: nextState = STATE_CALL_DISP;
            STATE_CALL_DISP: nextState = STATE_PC_ADD;
            STATE_PC_ADD:    nextState = STATE_FETCH;
            STATE_PC_INC:    nextState = STATE_FETCH;
            STATE_HALT:      nextState = STATE_HALT;
            default:         nextState = STATE_IDLE;
        endcase
    end

    always_ff @(posedge SC_UCONTROL_CLOCK_50) begin
        if (SC_UCONTROL_Reset_InHigh) begin
            state   <= STATE_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= nextState;
            if (setIllegal) illegal <= 1'b1;
        end
    end

    // Reset also masks the outputs so an ack landing in the reset cycle cannot load IR.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (!SC_UCONTROL_Reset_InHigh) begin
            case (state)
                STATE_FETCH: begin
                    ctrl.memReq = 1'b1;
                    ctrl.muxA   = MUX_PC;
                    if (SC_UCONTROL_MemAck_InHigh) begin
                        ctrl.dec     = DEC_IR;
                        ctrl.busCSel = 1'b1;
                    end
                end
                STATE_ALU: begin
                    ctrl.muxA = MW'(SC_UCONTROL_RegIR_RS1);
                    ctrl.muxB = SC_UCONTROL_RegIR_BIT13 ? MUX_TEMP0 : MW'(SC_UCONTROL_RegIR_RS2);
                    ctrl.alu  = aluOp;
                    ctrl.dec  = rdDec;
                end
                STATE_IMM: begin
                    ctrl.muxA = MUX_IR;
                    ctrl.alu  = ALU_SIMM13;
                    ctrl.dec  = DEC_TEMP0;
                end
                STATE_SETHI: begin
                    ctrl.muxA = MUX_IR;
                    ctrl.alu  = ALU_SETHI;
                    ctrl.dec  = rdDec;
                end
                STATE_BR_DISP: begin
                    ctrl.muxA = MUX_IR;
                    ctrl.alu  = ALU_DISP22;
                    ctrl.dec  = DEC_TEMP0;
                end
                STATE_CALL_LINK: begin
                    ctrl.muxA = MUX_PC;
                    ctrl.muxB = MUX_R0;
                    ctrl.alu  = ALU_ADD;
                    ctrl.dec  = DEC_LINK;
                end
                STATE_CALL_DISP: begin
                    ctrl.muxA = MUX_IR;
                    ctrl.alu  = ALU_DISP30;
                    ctrl.dec  = DEC_TEMP0;
                end
                STATE_PC_ADD: begin
                    ctrl.muxA = MUX_PC;
                    ctrl.muxB = MUX_TEMP0;
                    ctrl.alu  = ALU_ADD;
                    ctrl.dec  = DEC_PC;
                end
                STATE_PC_INC: begin
                    ctrl.muxA = MUX_PC;
                    ctrl.alu  = ALU_INCPC;
                    ctrl.dec  = DEC_PC;
                end
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign SC_UCONTROL_MemReq_OutHigh            = ctrl.memReq;
    assign SC_UCONTROL_DecoderSelectionWrite_Out = ctrl.dec;
    assign SC_UCONTROL_MUXSelectionBUSA_Out      = ctrl.muxA;
    assign SC_UCONTROL_MUXSelectionBUSB_Out      = ctrl.muxB;
    assign SC_UCONTROL_ALUSelection_Out          = ctrl.alu;
    assign SC_UCONTROL_BusCSel_Out               = ctrl.busCSel;
    assign SC_UCONTROL_Illegal_OutHigh           = illegal & ~SC_UCONTROL_Reset_InHigh;
endmodule
